// File: rtl/level_sequencer.sv
// level_sequencer
//   Game-flow controller placed after the per-level modules. It uses the win
//   and lose flags of the selected level to decide the active level, the
//   remaining lives and the screen mode. It also holds the level modules in
//   reset while a level is (re)loading.
//
// Ports
//   vga_clock_i      system clock
//   reset_i          synchronous, active-high reset
//   start_button_i   synchronised start button; only its rising edge is used
//   level_win_i      win flag of the currently selected level
//   level_lose_i     lose flag of the currently selected level
//   level_select_o   index of the active level (drives the level mux)
//   level_reset_n_o  active-low reset to all level modules
//   screen_mode_o    0 TITLE,1 LOAD,2 PLAY,3 CLEAR,4 DEATH,5 GAME_OVER,6 VICTORY
//   lives_o          remaining lives
//   leds_o           [9:8] level_select, [7:0] thermometer of lives
//
// state      | meaning
// -----------+------------------------------------------------------------
// TITLE      | title screen, levels in reset, waiting for a start edge
// LOAD       | level held in reset for LOAD_CYCLES cycles
// PLAY       | level running; first cycle ignores win/lose
// CLEAR      | level-cleared banner for BANNER_CYCLES, then next level
// DEATH      | life-lost banner for BANNER_CYCLES, then reload same level
// GAME_OVER  | no lives left, waiting for a start edge
// VICTORY    | last level cleared, waiting for a start edge
module level_sequencer #(
   parameter int NUM_LEVELS    = 4,
   parameter int START_LIVES   = 3,
   parameter int LOAD_CYCLES   = 4,
   parameter int BANNER_CYCLES = 50_000_000
) (
   input  logic       vga_clock_i,
   input  logic       reset_i,
   input  logic       start_button_i,
   input  logic       level_win_i,
   input  logic       level_lose_i,
   output logic [1:0] level_select_o,
   output logic       level_reset_n_o,
   output logic [2:0] screen_mode_o,
   output logic [3:0] lives_o,
   output logic [9:0] leds_o
);

   typedef enum logic [2:0] {
      S_TITLE     = 3'd0,
      S_LOAD      = 3'd1,
      S_PLAY      = 3'd2,
      S_CLEAR     = 3'd3,
      S_DEATH     = 3'd4,
      S_GAME_OVER = 3'd5,
      S_VICTORY   = 3'd6
   } state_t;

   localparam int CNT_MAX = (BANNER_CYCLES > LOAD_CYCLES) ? BANNER_CYCLES : LOAD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_CYCLES - 1);
   localparam logic [1:0]       LAST_LEVEL  = 2'(NUM_LEVELS - 1);
   localparam logic [3:0]       LIVES_INIT  = 4'(START_LIVES);

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [3:0]       lives_q, lives_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_q;
   logic             rstn_q, rstn_d;
   logic [9:0]       leds_q, leds_d;
   logic [7:0]       therm_d;
   logic             start_edge;

   assign start_edge = start_button_i & ~start_q;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      lives_d = lives_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_TITLE: begin
            if (start_edge) begin
               state_d = S_LOAD;
               sel_d   = 2'd0;
               lives_d = LIVES_INIT;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (cnt_q == LOAD_LAST) begin
               state_d = S_PLAY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PLAY: begin
            // cnt_q == 0 marks the first PLAY cycle while levels leave reset
            if (cnt_q == '0) begin
               cnt_d = CNT_W'(1);
            end else if (level_win_i) begin
               state_d = (sel_q == LAST_LEVEL) ? S_VICTORY : S_CLEAR;
               cnt_d   = '0;
            end else if (level_lose_i) begin
               cnt_d = '0;
               if (lives_q <= 4'd1) begin
                  lives_d = 4'd0;
                  state_d = S_GAME_OVER;
               end else begin
                  lives_d = lives_q - 4'd1;
                  state_d = S_DEATH;
               end
            end
         end
         S_CLEAR, S_DEATH: begin
            if (cnt_q == BANNER_LAST) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               if (state_q == S_CLEAR && sel_q != LAST_LEVEL)
                  sel_d = sel_q + 2'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAME_OVER, S_VICTORY: begin
            if (start_edge) begin
               state_d = S_TITLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_TITLE;
            cnt_d   = '0;
         end
      endcase

      rstn_d = !(state_d == S_TITLE || state_d == S_LOAD);

      therm_d = '0;
      for (int i = 0; i < 8; i++)
         therm_d[i] = (lives_d > 4'(i));
      leds_d = {sel_d, therm_d};
   end

   always_ff @(posedge vga_clock_i) begin
      if (reset_i) begin
         state_q <= S_TITLE;
         sel_q   <= 2'd0;
         lives_q <= LIVES_INIT;
         cnt_q   <= '0;
         start_q <= 1'b0;
         rstn_q  <= 1'b0;
         leds_q  <= {2'd0, 8'(~(8'hFF << START_LIVES))};
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         lives_q <= lives_d;
         cnt_q   <= cnt_d;
         start_q <= start_button_i;
         rstn_q  <= rstn_d;
         leds_q  <= leds_d;
      end
   end

   assign level_select_o  = sel_q;
   assign level_reset_n_o = rstn_q;
   assign screen_mode_o   = state_q;
   assign lives_o         = lives_q;
   assign leds_o          = leds_q;

endmodule

// File: tb/tb_level_sequencer.sv
module tb_level_sequencer;

   logic       clk;
   logic       rst;
   logic       start_b;
   logic       win;
   logic       lose;
   logic [1:0] sel;
   logic       rstn;
   logic [2:0] mode;
   logic [3:0] lives;
   logic [9:0] leds;

   int tests_run = 0;
   int tests_failed = 0;

   level_sequencer #(
      .NUM_LEVELS   (4),
      .START_LIVES  (3),
      .LOAD_CYCLES  (4),
      .BANNER_CYCLES(8)
   ) dut (
      .vga_clock_i    (clk),
      .reset_i        (rst),
      .start_button_i (start_b),
      .level_win_i    (win),
      .level_lose_i   (lose),
      .level_select_o (sel),
      .level_reset_n_o(rstn),
      .screen_mode_o  (mode),
      .lives_o        (lives),
      .leds_o         (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [2:0] TITLE = 3'd0, LOAD = 3'd1, PLAY = 3'd2, CLEAR = 3'd3,
                          DEATH = 3'd4, GOVER = 3'd5, VICT = 3'd6;

   typedef struct {
      bit         rst, st, win, lose;
      int         n;
      logic [2:0] mode;
      logic [1:0] sel;
      logic [3:0] lives;
      logic       rstn;
   } vec_t;

   typedef struct {
      logic [2:0] mode;
      logic [1:0] sel;
      logic [3:0] lives;
      logic       rstn;
      logic [9:0] leds;
      int         idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic logic [9:0] model_leds(logic [1:0] s, logic [3:0] l);
      logic [9:0] r;
      r[9:8] = s;
      for (int i = 0; i < 8; i++) r[i] = (int'(l) > i);
      return r;
   endfunction

   function automatic void add(bit r, bit s, bit w, bit lo, int n,
                               logic [2:0] m, logic [1:0] se, logic [3:0] li, logic rn);
      vec_t v;
      v.rst = r; v.st = s; v.win = w; v.lose = lo; v.n = n;
      v.mode = m; v.sel = se; v.lives = li; v.rstn = rn;
      vecs.push_back(v);
   endfunction

   // one full level reload after a banner: LOAD x4 then two PLAY cycles
   function automatic void reload(logic [1:0] se, logic [3:0] li, bit w);
      add(0, 0, w, 0, 1, LOAD, se, li, 0);
      add(0, 0, w, 0, 3, LOAD, se, li, 0);
      add(0, 0, w, 0, 1, PLAY, se, li, 1);
      add(0, 0, w, 0, 1, PLAY, se, li, 1);
   endfunction

   initial begin
      exp_t e, g;
      int   ld_cnt, waited;
      bit   seen;

      rst = 1'b1; start_b = 1'b0; win = 1'b0; lose = 1'b0;

      // 1: reset, start, exactly four LOAD cycles, then PLAY
      add(1, 0, 0, 0, 2, TITLE, 0, 3, 0);
      add(0, 0, 0, 0, 2, TITLE, 0, 3, 0);
      add(0, 1, 0, 0, 1, LOAD,  0, 3, 0);
      add(0, 1, 0, 0, 3, LOAD,  0, 3, 0);
      add(0, 0, 0, 0, 1, PLAY,  0, 3, 1);
      // 2: win held through first PLAY, CLEAR, LOAD and next first PLAY cycle
      add(0, 0, 1, 0, 1, PLAY,  0, 3, 1);
      add(0, 0, 1, 0, 1, CLEAR, 0, 3, 1);
      add(0, 0, 1, 0, 7, CLEAR, 0, 3, 1);
      reload(1, 3, 1);
      add(0, 0, 0, 0, 3, PLAY,  1, 3, 1);
      // 3: three losses -> GAME_OVER, start back to TITLE, start again
      add(0, 0, 0, 1, 1, DEATH, 1, 2, 1);
      add(0, 0, 0, 0, 7, DEATH, 1, 2, 1);
      reload(1, 2, 0);
      add(0, 0, 0, 1, 1, DEATH, 1, 1, 1);
      add(0, 0, 0, 0, 7, DEATH, 1, 1, 1);
      reload(1, 1, 0);
      add(0, 0, 0, 1, 1, GOVER, 1, 0, 1);
      add(0, 0, 0, 1, 2, GOVER, 1, 0, 1);
      add(0, 1, 0, 0, 1, TITLE, 1, 0, 0);
      add(0, 0, 0, 0, 1, TITLE, 1, 0, 0);
      add(0, 1, 0, 0, 1, LOAD,  0, 3, 0);
      add(0, 1, 0, 0, 3, LOAD,  0, 3, 0);
      add(0, 0, 0, 0, 2, PLAY,  0, 3, 1);
      // 4: win and lose together -> CLEAR, lives unchanged
      add(0, 0, 1, 1, 1, CLEAR, 0, 3, 1);
      add(0, 0, 0, 0, 7, CLEAR, 0, 3, 1);
      reload(1, 3, 0);
      add(0, 0, 1, 0, 1, CLEAR, 1, 3, 1);
      add(0, 0, 0, 0, 7, CLEAR, 1, 3, 1);
      reload(2, 3, 0);
      add(0, 0, 1, 0, 1, CLEAR, 2, 3, 1);
      add(0, 0, 0, 0, 7, CLEAR, 2, 3, 1);
      add(0, 0, 0, 0, 1, LOAD,  3, 3, 0);
      add(0, 0, 0, 0, 3, LOAD,  3, 3, 0);
      add(0, 0, 0, 0, 1, PLAY,  3, 3, 1);
      // 5: start raised in PLAY (ignored), win on level 3 -> VICTORY held
      add(0, 1, 0, 0, 1, PLAY,  3, 3, 1);
      add(0, 1, 1, 0, 1, VICT,  3, 3, 1);
      add(0, 1, 1, 0, 3, VICT,  3, 3, 1);
      add(0, 0, 0, 0, 1, VICT,  3, 3, 1);
      add(0, 1, 0, 0, 1, TITLE, 3, 3, 0);
      // 6: reset mid-LOAD, then reset mid-CLEAR on level 1 with lives 2
      add(0, 0, 0, 0, 1, TITLE, 3, 3, 0);
      add(0, 1, 0, 0, 1, LOAD,  0, 3, 0);
      add(0, 0, 0, 0, 1, LOAD,  0, 3, 0);
      add(1, 0, 0, 0, 1, TITLE, 0, 3, 0);
      add(0, 1, 0, 0, 1, LOAD,  0, 3, 0);
      add(0, 0, 0, 0, 3, LOAD,  0, 3, 0);
      add(0, 0, 0, 0, 2, PLAY,  0, 3, 1);
      add(0, 0, 0, 1, 1, DEATH, 0, 2, 1);
      add(0, 0, 0, 0, 7, DEATH, 0, 2, 1);
      reload(0, 2, 0);
      add(0, 0, 1, 0, 1, CLEAR, 0, 2, 1);
      add(0, 0, 0, 0, 7, CLEAR, 0, 2, 1);
      reload(1, 2, 0);
      add(0, 0, 1, 0, 1, CLEAR, 1, 2, 1);
      add(0, 0, 0, 0, 3, CLEAR, 1, 2, 1);
      add(1, 0, 0, 0, 1, TITLE, 0, 3, 0);
      add(0, 0, 0, 0, 1, TITLE, 0, 3, 0);

      foreach (vecs[k]) begin
         for (int c = 0; c < vecs[k].n; c++) begin
            @(negedge clk);
            rst = vecs[k].rst; start_b = vecs[k].st;
            win = vecs[k].win; lose = vecs[k].lose;
            e.mode = vecs[k].mode; e.sel = vecs[k].sel; e.lives = vecs[k].lives;
            e.rstn = vecs[k].rstn; e.leds = model_leds(vecs[k].sel, vecs[k].lives);
            e.idx = k;
            sb.push_back(e);
            @(posedge clk);
            #1;
            g = sb.pop_front();
            tests_run++;
            if (mode !== g.mode || sel !== g.sel || lives !== g.lives ||
                rstn !== g.rstn || leds !== g.leds) begin
               tests_failed++;
               $display("FAIL vec%0d.%0d got mode=%0d sel=%0d lives=%0d rstn=%b leds=%b want mode=%0d sel=%0d lives=%0d rstn=%b leds=%b",
                        g.idx, c, mode, sel, lives, rstn, leds,
                        g.mode, g.sel, g.lives, g.rstn, g.leds);
            end
         end
      end

      // hand sequence: count LOAD cycles until PLAY, bounded wait
      @(negedge clk); rst = 1'b1; start_b = 1'b0; win = 1'b0; lose = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); start_b = 1'b1;
      ld_cnt = 0; seen = 0; waited = 0;
      while (!seen && waited < 30) begin
         @(posedge clk); #1;
         waited++;
         if (mode == LOAD) begin
            ld_cnt++;
            tests_run++;
            if (rstn !== 1'b0) begin
               tests_failed++;
               $display("FAIL load_rstn got %b want 0", rstn);
            end
         end
         if (mode == PLAY) seen = 1;
      end
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL play_timeout got mode=%0d want %0d within 30 cycles", mode, PLAY);
      end
      tests_run++;
      if (ld_cnt != 4) begin
         tests_failed++;
         $display("FAIL load_len got %0d want 4", ld_cnt);
      end
      tests_run++;
      if (leds !== 10'b00_0000_0111 || rstn !== 1'b1 || sel !== 2'd0 || lives !== 4'd3) begin
         tests_failed++;
         $display("FAIL play_entry got leds=%b rstn=%b sel=%0d lives=%0d want leds=0000000111 rstn=1 sel=0 lives=3",
                  leds, rstn, sel, lives);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
